// File: rtl/obj_pkg.sv
// Shared OBJ-engine types: OAM geometry, OAM port owner tags and arbiter states.
package obj_pkg;

    localparam int OAM_AW = 8;
    localparam int OAM_DW = 32;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_OBJ,
        OWN_ATTR,
        OWN_CPU
    } oam_owner_t;

    typedef enum logic [1:0] {
        ARB_RENDER,
        ARB_ATTR_BURST,
        ARB_CPU
    } arb_state_t;

endpackage

// File: rtl/oam_tag_pipe.sv
// Owner-tag delay line matching the OAM read latency; the tag at the end
// tells the arbiter which requester the returning read data belongs to.
module oam_tag_pipe
    import obj_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  oam_owner_t tag_i,
    output oam_owner_t tag_o
);

    oam_owner_t pipe_q [DEPTH];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe_q[i] <= OWN_NONE;
            end
        end else begin
            pipe_q[0] <= tag_i;
            for (int i = 1; i < DEPTH; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign tag_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/oam_port_arbiter.sv
// Single-port OAM arbiter: object sweep, affine attribute bursts and CPU in blanking.
// Optional OAM_ARB_CPU_ANYTIME_EN lets the CPU take otherwise idle render cycles.
//
// state          | meaning
// ARB_RENDER     | render requesters by fixed priority, CPU only inside its window
// ARB_ATTR_BURST | affine fetch holds the port while attr_req stays high
// ARB_CPU        | CPU owned the last cycle; keeps it while window and request hold
module oam_port_arbiter
    import obj_pkg::*;
#(
    parameter int AW     = OAM_AW,
    parameter int DW     = OAM_DW,
    parameter int RD_LAT = 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          obj_req,
    input  logic [AW-1:0] obj_addr,
    output logic          obj_gnt,
    output logic          obj_rvalid,
    input  logic          attr_req,
    input  logic [AW-1:0] attr_addr,
    output logic          attr_gnt,
    output logic          attr_rvalid,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    input  logic [3:0]    cpu_be,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    input  logic          hblank,
    input  logic          vblank,
    input  logic          hblank_free,
    input  logic          forced_blank,
    output logic [AW-1:0] oam_addr,
    output logic          oam_we,
    output logic [3:0]    oam_be,
    output logic [DW-1:0] oam_wdata,
    input  logic [DW-1:0] oam_rdata,
    output logic [DW-1:0] rdata,
    output logic          cpu_wait
);

    arb_state_t state_q, state_d;
    oam_owner_t own;
    oam_owner_t tag_in;
    oam_owner_t tag_out;
    logic       cpu_win;
    logic       cpu_open;
    logic       cpu_late;

    assign cpu_win  = vblank | forced_blank | (hblank & hblank_free);
    assign cpu_open = cpu_req & cpu_win;

`ifdef OAM_ARB_CPU_ANYTIME_EN
    assign cpu_late = cpu_req;
`else
    assign cpu_late = 1'b0;
`endif

    // ARB_CPU falls back to the render priority order in the same cycle.
    always_comb begin
        own     = OWN_NONE;
        state_d = state_q;
        case (state_q)
            ARB_ATTR_BURST: begin
                if (attr_req) begin
                    own = OWN_ATTR;
                end else begin
                    state_d = ARB_RENDER;
                end
            end
            default: begin
                if (cpu_open) begin
                    own     = OWN_CPU;
                    state_d = ARB_CPU;
                end else if (attr_req) begin
                    own     = OWN_ATTR;
                    state_d = ARB_ATTR_BURST;
                end else if (obj_req) begin
                    own     = OWN_OBJ;
                    state_d = ARB_RENDER;
                end else if (cpu_late) begin
                    own     = OWN_CPU;
                    state_d = ARB_RENDER;
                end else begin
                    state_d = ARB_RENDER;
                end
            end
        endcase
        if (!reset) begin
            own = OWN_NONE;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ARB_RENDER;
        end else begin
            state_q <= state_d;
        end
    end

    assign obj_gnt  = (own == OWN_OBJ);
    assign attr_gnt = (own == OWN_ATTR);
    assign cpu_gnt  = (own == OWN_CPU);
    assign cpu_wait = reset & cpu_req & ~cpu_gnt;

    always_comb begin
        case (own)
            OWN_OBJ:  oam_addr = obj_addr;
            OWN_ATTR: oam_addr = attr_addr;
            OWN_CPU:  oam_addr = cpu_addr;
            default:  oam_addr = '0;
        endcase
    end

    assign oam_we    = cpu_gnt & cpu_we;
    assign oam_be    = oam_we ? cpu_be : 4'hF;
    assign oam_wdata = oam_we ? cpu_wdata : '0;

    // Writes return nothing, so they occupy a pipe slot as an empty tag.
    assign tag_in = oam_we ? OWN_NONE : own;

    oam_tag_pipe #(
        .DEPTH (RD_LAT)
    ) u_tag_pipe (
        .clock (clock),
        .reset (reset),
        .tag_i (tag_in),
        .tag_o (tag_out)
    );

    assign obj_rvalid  = (tag_out == OWN_OBJ);
    assign attr_rvalid = (tag_out == OWN_ATTR);
    assign cpu_rvalid  = (tag_out == OWN_CPU);
    assign rdata       = oam_rdata;

endmodule

// File: tb/tb_oam_port_arbiter.sv
// Scoreboard bench for oam_port_arbiter: directed scenarios then random traffic.
module tb_oam_port_arbiter;

    localparam int AW     = 8;
    localparam int DW     = 32;
    localparam int RD_LAT = 3;

    typedef struct {
        logic [2:0]    gnt;
        logic [AW-1:0] addr;
        logic          we;
        logic [3:0]    be;
        logic [DW-1:0] wdata;
        logic          cwait;
    } gexp_t;

    typedef struct {
        logic [2:0]    own_vec;
        logic [DW-1:0] data;
        int            due;
    } rexp_t;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          obj_req = 1'b0, attr_req = 1'b0, cpu_req = 1'b0, cpu_we = 1'b0;
    logic [AW-1:0] obj_addr = '0, attr_addr = '0, cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic [3:0]    cpu_be = 4'hF;
    logic          hblank = 1'b0, vblank = 1'b0, hblank_free = 1'b0, forced_blank = 1'b0;
    logic          obj_gnt, obj_rvalid, attr_gnt, attr_rvalid, cpu_gnt, cpu_rvalid, cpu_wait;
    logic [AW-1:0] oam_addr;
    logic          oam_we;
    logic [3:0]    oam_be;
    logic [DW-1:0] oam_wdata, oam_rdata, rdata;

    logic [DW-1:0] mem     [256];
    logic [DW-1:0] ref_mem [256];
    logic [DW-1:0] rpipe   [RD_LAT];

    gexp_t gnt_q[$];
    rexp_t rd_q[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    bit    m_lock = 0;
    int    m_own = 0;

    oam_port_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
        .clock(clock), .reset(reset),
        .obj_req(obj_req), .obj_addr(obj_addr), .obj_gnt(obj_gnt), .obj_rvalid(obj_rvalid),
        .attr_req(attr_req), .attr_addr(attr_addr), .attr_gnt(attr_gnt), .attr_rvalid(attr_rvalid),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_be(cpu_be), .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
        .hblank(hblank), .vblank(vblank), .hblank_free(hblank_free), .forced_blank(forced_blank),
        .oam_addr(oam_addr), .oam_we(oam_we), .oam_be(oam_be), .oam_wdata(oam_wdata),
        .oam_rdata(oam_rdata), .rdata(rdata), .cpu_wait(cpu_wait)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // OAM RAM with RD_LAT cycles of read latency.
    always @(posedge clock) begin
        if (oam_we) begin
            for (int b = 0; b < 4; b++) begin
                if (oam_be[b]) mem[oam_addr][8*b +: 8] <= oam_wdata[8*b +: 8];
            end
        end
        rpipe[0] <= mem[oam_addr];
        for (int i = 1; i < RD_LAT; i++) rpipe[i] <= rpipe[i-1];
    end
    assign oam_rdata = rpipe[RD_LAT-1];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Reference: the port goes to whoever the rules pick; a granted attr
    // word locks the port for as long as attr_req stays high.
    task automatic step();
        gexp_t g;
        rexp_t r;
        logic  win;
        int    own;
        win = vblank | forced_blank | (hblank & hblank_free);
        own = 0;
        if (!reset) begin
            m_lock = 0;
            rd_q.delete();
        end else if (m_lock) own = attr_req ? 2 : 0;
        else if (cpu_req && win) own = 3;
        else if (attr_req) own = 2;
        else if (obj_req) own = 1;
`ifdef OAM_ARB_CPU_ANYTIME_EN
        else if (cpu_req) own = 3;
`endif
        m_lock  = (own == 2);
        m_own   = own;
        g.gnt   = {own == 1, own == 2, own == 3};
        g.addr  = (own == 1) ? obj_addr : (own == 2) ? attr_addr : (own == 3) ? cpu_addr : 8'h00;
        g.we    = (own == 3) && cpu_we;
        g.be    = g.we ? cpu_be : 4'hF;
        g.wdata = cpu_wdata;
        g.cwait = reset && cpu_req && (own != 3);
        gnt_q.push_back(g);
        if (g.we) begin
            for (int b = 0; b < 4; b++) begin
                if (cpu_be[b]) ref_mem[g.addr][8*b +: 8] = cpu_wdata[8*b +: 8];
            end
        end else if (own != 0) begin
            r.own_vec = g.gnt;
            r.data    = ref_mem[g.addr];
            r.due     = cyc + RD_LAT;
            rd_q.push_back(r);
        end
        @(posedge clock);
        #1;
    endtask

    always @(negedge clock) begin
        gexp_t      g;
        rexp_t      r;
        logic [2:0] rv;
        if (gnt_q.size() > 0) begin
            g = gnt_q.pop_front();
            chk("grants", {obj_gnt, attr_gnt, cpu_gnt}, g.gnt);
            chk("oam_addr", oam_addr, g.addr);
            chk("oam_we", oam_we, g.we);
            chk("oam_be", oam_be, g.be);
            chk("cpu_wait", cpu_wait, g.cwait);
            if (g.we) chk("oam_wdata", oam_wdata, g.wdata);
        end
        rv = {obj_rvalid, attr_rvalid, cpu_rvalid};
        if (rv !== 3'b000) begin
            if (rd_q.size() == 0) begin
                chk("unexpected_rvalid", rv, 3'b000);
            end else begin
                r = rd_q.pop_front();
                chk("rvalid_cycle", cyc, r.due);
                chk("rvalid_owner", rv, r.own_vec);
                chk("rdata", rdata, r.data);
            end
        end else if (rd_q.size() > 0 && rd_q[0].due <= cyc) begin
            r = rd_q.pop_front();
            chk("missing_rvalid", rv, r.own_vec);
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        @(posedge clock);
        #1;
        // Reset: grants stay low even with a request present.
        step();
        obj_req = 1; obj_addr = 8'h10;
        step();
        reset = 1;
        // Single object read.
        step();
        obj_req = 0;
        repeat (4) step();
        // Affine burst starves a waiting object read; gap cycle, then OBJ.
        obj_req = 1; obj_addr = 8'h20; attr_req = 1;
        for (int i = 0; i < 4; i++) begin
            attr_addr = 8'h03 + 8'(8 * i);
            step();
        end
        attr_req = 0;
        step();
        step();
        obj_req = 0;
        repeat (3) step();
        // CPU write in vblank beats a pending attr request.
        vblank = 1; cpu_req = 1; cpu_we = 1; cpu_be = 4'b0011; cpu_addr = 8'h40;
        cpu_wdata = 32'hA5A5_1234; attr_req = 1; attr_addr = 8'h03;
        step();
        cpu_req = 0; vblank = 0;
        for (int i = 0; i < 4; i++) begin
            attr_addr = 8'h03 + 8'(8 * i);
            step();
        end
        attr_req = 0;
        step();
        obj_req = 1; obj_addr = 8'h40;
        step();
        obj_req = 0;
        repeat (3) step();
        // hblank without hblank_free is not a CPU window.
        hblank = 1; hblank_free = 0; cpu_req = 1; cpu_we = 0; cpu_addr = 8'h05;
        step();
        cpu_req = 0; hblank = 0;
        step();
        // Reads in flight are dropped by reset.
        for (int i = 1; i <= 3; i++) begin
            obj_req = 1; obj_addr = 8'(i);
            step();
        end
        obj_req = 0; reset = 0;
        repeat (2) step();
        reset = 1;
        repeat (6) step();
        // Window closes during a CPU read stream; last grant still returns.
        vblank = 1; cpu_req = 1; cpu_we = 0;
        for (int i = 0; i < 3; i++) begin
            cpu_addr = 8'h50 + 8'(i);
            step();
        end
        cpu_addr = 8'h53; vblank = 0;
        step();
        cpu_req = 0;
        repeat (5) step();
        // Random traffic with requesters that hold until granted.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 15) == 0) vblank = ~vblank;
            if ($urandom_range(0, 5) == 0) hblank = ~hblank;
            if ($urandom_range(0, 31) == 0) hblank_free = ~hblank_free;
            if ($urandom_range(0, 63) == 0) forced_blank = ~forced_blank;
            if (!obj_req && $urandom_range(0, 2) == 0) begin
                obj_req = 1; obj_addr = 8'($urandom);
            end
            if (!attr_req && $urandom_range(0, 7) == 0) begin
                attr_req = 1; attr_addr = 8'($urandom_range(0, 31) * 8 + 3);
            end
            if (!cpu_req && $urandom_range(0, 3) == 0) begin
                cpu_req = 1; cpu_we = 1'($urandom); cpu_addr = 8'($urandom);
                cpu_wdata = $urandom; cpu_be = 4'($urandom);
            end
            step();
            if (m_own == 1) obj_req = 0;
            if (m_own == 3) cpu_req = 0;
            if (m_own == 2) begin
                attr_addr = attr_addr + 8'd8;
                if (attr_addr[7:3] == 5'd0 || $urandom_range(0, 3) == 0) attr_req = 0;
            end
        end
        obj_req = 0; attr_req = 0; cpu_req = 0;
        repeat (RD_LAT + 4) step();
        chk("scoreboard_drained", rd_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
